pipeline_ctrl: RTL and testbench



---
 rtl/pipeline_ctrl_pkg.sv | 21 ++
 rtl/pipeline_ctrl_hazard_cmp.sv | 37 +++
 rtl/pipeline_ctrl.sv | 137 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
package pipeline_ctrl_pkg;

  // Upper bounds for the stored types; REGISTER_WIDTH and $clog2(NB+1) must fit within them.
  localparam int unsigned MaxRegWidth = 8;
  localparam int unsigned MaxSelWidth = 4;

  typedef struct packed {
    logic                   valid;
    logic                   wr_en;
    logic [MaxRegWidth-1:0] wr_reg;
    logic                   is_load;
  } slot_t;

  typedef logic [MaxSelWidth-1:0] fwd_sel_t;

  function automatic int unsigned sel_width(input int unsigned nb);
    return $clog2(nb + 1);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_cmp.sv
// Per-operand comparator: finds the youngest back-end slot producing the source register.
module pipeline_ctrl_hazard_cmp
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned NB             = 3,
  parameter int unsigned FWD_EN         = 1,
  parameter int unsigned REGISTER_WIDTH = 5,
  parameter int unsigned SelW           = sel_width(NB)
) (
  input  slot_t [NB-1:0]             slots_i,
  input  logic [REGISTER_WIDTH-1:0]  rs_i,
  input  logic                       used_i,
  output logic                       stall_req_o,
  output logic [SelW-1:0]            sel_o
);

  logic found;

  always_comb begin
    found       = 1'b0;
    stall_req_o = 1'b0;
    sel_o       = '0;
    for (int k = 0; k < int'(NB); k++) begin
      if (!found && used_i && (rs_i != '0) && slots_i[k].valid && slots_i[k].wr_en &&
          (slots_i[k].wr_reg == MaxRegWidth'(rs_i))) begin
        found = 1'b1;
        // A load still in slot 1 has no result yet, so it cannot be forwarded.
        if ((FWD_EN == 0) || ((k == 0) && slots_i[k].is_load)) begin
          stall_req_o = 1'b1;
        end else begin
          sel_o = SelW'(k + 1);
        end
      end
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard, forwarding and flush controller with a shadow shift register of back-end slots.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REGISTER_WIDTH = 5,
  parameter int unsigned NUM_STAGES     = 5,
  parameter int unsigned FWD_EN         = 1,
  parameter int unsigned CNT_WIDTH      = 16,
  localparam int unsigned NB            = NUM_STAGES - 2,
  localparam int unsigned SelW          = sel_width(NB)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      dec_valid_i,
  input  logic [REGISTER_WIDTH-1:0] dec_rs_a_i,
  input  logic [REGISTER_WIDTH-1:0] dec_rs_b_i,
  input  logic                      dec_rs_a_used_i,
  input  logic                      dec_rs_b_used_i,
  input  logic                      dec_wr_en_i,
  input  logic [REGISTER_WIDTH-1:0] dec_wr_reg_i,
  input  logic                      dec_is_load_i,
  input  logic                      redirect_i,
  input  logic                      mem_busy_i,
  output logic                      stall_fetch_o,
  output logic                      stall_dec_o,
  output logic                      flush_o,
  output logic                      bubble_alu_o,
  output logic                      issue_o,
  output logic [SelW-1:0]           fwd_a_sel_o,
  output logic [SelW-1:0]           fwd_b_sel_o,
  output logic [NB-1:0]             slot_valid_o,
  output logic [CNT_WIDTH-1:0]      stall_cnt_o,
  output logic [CNT_WIDTH-1:0]      flush_cnt_o
);

  slot_t [NB-1:0]       slots_q, slots_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                 stall_a, stall_b, hazard;

  pipeline_ctrl_hazard_cmp #(
    .NB             (NB),
    .FWD_EN         (FWD_EN),
    .REGISTER_WIDTH (REGISTER_WIDTH),
    .SelW           (SelW)
  ) u_cmp_a (
    .slots_i     (slots_q),
    .rs_i        (dec_rs_a_i),
    .used_i      (dec_rs_a_used_i),
    .stall_req_o (stall_a),
    .sel_o       (fwd_a_sel_o)
  );

  pipeline_ctrl_hazard_cmp #(
    .NB             (NB),
    .FWD_EN         (FWD_EN),
    .REGISTER_WIDTH (REGISTER_WIDTH),
    .SelW           (SelW)
  ) u_cmp_b (
    .slots_i     (slots_q),
    .rs_i        (dec_rs_b_i),
    .used_i      (dec_rs_b_used_i),
    .stall_req_o (stall_b),
    .sel_o       (fwd_b_sel_o)
  );

  assign hazard = dec_valid_i && (stall_a || stall_b);

  always_comb begin
    stall_fetch_o = 1'b0;
    stall_dec_o   = 1'b0;
    flush_o       = 1'b0;
    bubble_alu_o  = 1'b0;
    issue_o       = 1'b0;
    if (mem_busy_i) begin
      stall_fetch_o = 1'b1;
      stall_dec_o   = 1'b1;
    end else if (redirect_i) begin
      // The decode instruction is killed, so any hazard it carries is irrelevant.
      flush_o      = 1'b1;
      bubble_alu_o = 1'b1;
    end else if (hazard) begin
      stall_fetch_o = 1'b1;
      stall_dec_o   = 1'b1;
      bubble_alu_o  = 1'b1;
    end else begin
      issue_o = dec_valid_i;
    end
  end

  always_comb begin
    slots_d     = slots_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!mem_busy_i) begin
      for (int k = 1; k < int'(NB); k++) begin
        slots_d[k] = slots_q[k-1];
      end
      slots_d[0] = '0;
      if (issue_o) begin
        slots_d[0].valid   = 1'b1;
        slots_d[0].wr_en   = dec_wr_en_i;
        slots_d[0].wr_reg  = MaxRegWidth'(dec_wr_reg_i);
        slots_d[0].is_load = dec_is_load_i;
      end
    end
    if (stall_dec_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush_o && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slots_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      slots_q     <= slots_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    slot_valid_o = '0;
    for (int k = 0; k < int'(NB); k++) begin
      slot_valid_o[k] = slots_q[k].valid;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench: forwarding and stall-only controllers against an instruction-level model.
module tb_pipeline_ctrl;

  localparam int NB     = 3;
  localparam int NCYC   = 800;
  localparam int MAXC_A = 65535;
  localparam int MAXC_B = 15;

  typedef struct packed {
    logic       v;
    logic [4:0] ra;
    logic [4:0] rb;
    logic       ua;
    logic       ub;
    logic       we;
    logic [4:0] wr;
    logic       ld;
  } ins_t;

  typedef struct packed {
    logic        sf;
    logic        sd;
    logic        fl;
    logic        bub;
    logic        iss;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [2:0]  sv;
    logic [15:0] sc;
    logic [15:0] fc;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy = 1'b0;
  logic redir = 1'b0;
  ins_t in_a = '0;
  ins_t in_b = '0;

  logic a_sf, a_sd, a_fl, a_bub, a_iss, b_sf, b_sd, b_fl, b_bub, b_iss;
  logic [1:0]  a_fa, a_fb, b_fa, b_fb;
  logic [2:0]  a_sv, b_sv;
  logic [15:0] a_sc, a_fc;
  logic [3:0]  b_sc, b_fc;
  obs_t        obs_a, obs_b;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .REGISTER_WIDTH (5),
    .NUM_STAGES     (5),
    .FWD_EN         (1),
    .CNT_WIDTH      (16)
  ) u_dut_a (
    .clk_i           (clk),
    .rst_i           (rst),
    .dec_valid_i     (in_a.v),
    .dec_rs_a_i      (in_a.ra),
    .dec_rs_b_i      (in_a.rb),
    .dec_rs_a_used_i (in_a.ua),
    .dec_rs_b_used_i (in_a.ub),
    .dec_wr_en_i     (in_a.we),
    .dec_wr_reg_i    (in_a.wr),
    .dec_is_load_i   (in_a.ld),
    .redirect_i      (redir),
    .mem_busy_i      (busy),
    .stall_fetch_o   (a_sf),
    .stall_dec_o     (a_sd),
    .flush_o         (a_fl),
    .bubble_alu_o    (a_bub),
    .issue_o         (a_iss),
    .fwd_a_sel_o     (a_fa),
    .fwd_b_sel_o     (a_fb),
    .slot_valid_o    (a_sv),
    .stall_cnt_o     (a_sc),
    .flush_cnt_o     (a_fc)
  );

  pipeline_ctrl #(
    .REGISTER_WIDTH (5),
    .NUM_STAGES     (5),
    .FWD_EN         (0),
    .CNT_WIDTH      (4)
  ) u_dut_b (
    .clk_i           (clk),
    .rst_i           (rst),
    .dec_valid_i     (in_b.v),
    .dec_rs_a_i      (in_b.ra),
    .dec_rs_b_i      (in_b.rb),
    .dec_rs_a_used_i (in_b.ua),
    .dec_rs_b_used_i (in_b.ub),
    .dec_wr_en_i     (in_b.we),
    .dec_wr_reg_i    (in_b.wr),
    .dec_is_load_i   (in_b.ld),
    .redirect_i      (redir),
    .mem_busy_i      (busy),
    .stall_fetch_o   (b_sf),
    .stall_dec_o     (b_sd),
    .flush_o         (b_fl),
    .bubble_alu_o    (b_bub),
    .issue_o         (b_iss),
    .fwd_a_sel_o     (b_fa),
    .fwd_b_sel_o     (b_fb),
    .slot_valid_o    (b_sv),
    .stall_cnt_o     (b_sc),
    .flush_cnt_o     (b_fc)
  );

  always_comb begin
    obs_a = {a_sf, a_sd, a_fl, a_bub, a_iss, a_fa, a_fb, a_sv, a_sc, a_fc};
    obs_b = {b_sf, b_sd, b_fl, b_bub, b_iss, b_fa, b_fb, b_sv, 12'd0, b_sc, 12'd0, b_fc};
  end

  // Reference model: per configuration, the instructions occupying back-end slots 1..NB.
  bit         mv[2][NB];
  bit         mw[2][NB];
  bit         ml[2][NB];
  logic [4:0] mr[2][NB];
  int         msc[2];
  int         mfc[2];
  ins_t       cur[2];

  obs_t q_a[$];
  obs_t q_b[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 0;

  function automatic void find(input int c, input logic [4:0] rs, input logic used,
                               output bit st, output logic [1:0] sel);
    st  = 0;
    sel = '0;
    for (int k = 0; k < NB; k++) begin
      if (used && rs != 0 && mv[c][k] && mw[c][k] && mr[c][k] == rs) begin
        if (c == 1 || (k == 0 && ml[c][k])) st = 1;
        else sel = 2'(k + 1);
        return;
      end
    end
  endfunction

  function automatic obs_t predict(input int c);
    obs_t o;
    bit sa, sb;
    logic [1:0] fa, fb;
    find(c, cur[c].ra, cur[c].ua, sa, fa);
    find(c, cur[c].rb, cur[c].ub, sb, fb);
    o    = '0;
    o.fa = fa;
    o.fb = fb;
    if (busy) begin
      o.sf = 1; o.sd = 1;
    end else if (redir) begin
      o.fl = 1; o.bub = 1;
    end else if (cur[c].v && (sa || sb)) begin
      o.sf = 1; o.sd = 1; o.bub = 1;
    end else begin
      o.iss = cur[c].v;
    end
    o.sv = {mv[c][2], mv[c][1], mv[c][0]};
    o.sc = 16'(msc[c]);
    o.fc = 16'(mfc[c]);
    return o;
  endfunction

  function automatic void update(input int c, input obs_t o);
    int maxc;
    maxc = (c == 0) ? MAXC_A : MAXC_B;
    if (rst) begin
      for (int k = 0; k < NB; k++) begin
        mv[c][k] = 0; mw[c][k] = 0; ml[c][k] = 0; mr[c][k] = '0;
      end
      msc[c] = 0;
      mfc[c] = 0;
      return;
    end
    if (!busy) begin
      for (int k = NB - 1; k > 0; k--) begin
        mv[c][k] = mv[c][k-1]; mw[c][k] = mw[c][k-1];
        ml[c][k] = ml[c][k-1]; mr[c][k] = mr[c][k-1];
      end
      mv[c][0] = o.iss;
      mw[c][0] = cur[c].we;
      ml[c][0] = cur[c].ld;
      mr[c][0] = cur[c].wr;
    end
    if (o.sd && msc[c] < maxc) msc[c]++;
    if (o.fl && mfc[c] < maxc) mfc[c]++;
  endfunction

  function automatic ins_t mk(input logic [4:0] ra, input logic [4:0] rb, input logic ua,
                              input logic ub, input logic [4:0] wr, input logic ld);
    ins_t i;
    i.v = 1; i.ra = ra; i.rb = rb; i.ua = ua; i.ub = ub;
    i.we = (wr != 0); i.wr = wr; i.ld = ld;
    return i;
  endfunction

  ins_t dir[9];
  int   idx[2];

  function automatic ins_t next_ins(input int c);
    ins_t i;
    if (idx[c] < 9) begin
      i = dir[idx[c]];
      idx[c]++;
      return i;
    end
    i.v  = ($urandom_range(7) != 0);
    i.ra = 5'($urandom_range(7));
    i.rb = 5'($urandom_range(7));
    i.ua = ($urandom_range(3) != 0);
    i.ub = ($urandom_range(3) != 0);
    i.we = ($urandom_range(3) != 0);
    i.wr = 5'($urandom_range(7));
    i.ld = i.we && ($urandom_range(9) < 3);
    return i;
  endfunction

  // Stimulus: applies one vector per cycle and queues the model's expectation for it.
  initial begin
    obs_t pend[2];
    bit   have = 0;
    dir[0] = mk(5'd0, 5'd0, 0, 0, 5'd1, 0);
    dir[1] = mk(5'd3, 5'd4, 1, 1, 5'd2, 0);
    dir[2] = mk(5'd0, 5'd0, 0, 0, 5'd5, 0);
    dir[3] = mk(5'd5, 5'd0, 1, 0, 5'd6, 0);
    dir[4] = mk(5'd5, 5'd0, 1, 0, 5'd9, 0);
    dir[5] = mk(5'd0, 5'd0, 0, 0, 5'd7, 1);
    dir[6] = mk(5'd7, 5'd0, 1, 0, 5'd10, 0);
    dir[7] = mk(5'd0, 5'd0, 0, 0, 5'd8, 1);
    dir[8] = mk(5'd0, 5'd8, 0, 1, 5'd11, 0);
    idx[0] = 0;
    idx[1] = 0;
    cur[0] = '0;
    cur[1] = '0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      if (have) begin
        for (int c = 0; c < 2; c++) begin
          update(c, pend[c]);
          if (!pend[c].sd) cur[c] = next_ins(c);
        end
      end
      #1;
      if (cyc < 40) begin
        rst   = (cyc == 0 || cyc == 28);
        busy  = (cyc >= 24 && cyc <= 27);
        redir = (cyc == 10);
      end else begin
        redir = (busy && redir) ? 1'b1 : ($urandom_range(9) == 0);
        busy  = ($urandom_range(7) == 0);
        rst   = ($urandom_range(99) == 0);
      end
      in_a = cur[0];
      in_b = cur[1];
      pend[0] = predict(0);
      pend[1] = predict(1);
      q_a.push_back(pend[0]);
      q_b.push_back(pend[1]);
      have = 1;
    end
    repeat (2) @(negedge clk);
    done = 1;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d/%0d expectations left unchecked, required 0/0",
               q_a.size(), q_b.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Monitor: outputs are combinational, so each cycle presents one observation per DUT.
  initial begin
    obs_t e;
    while (!done) begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        vectors++;
        if (obs_a !== e) begin
          miscompares++;
          $display("FAIL fwd_cfg t=%0t: got %h required %h", $time, obs_a, e);
        end
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        vectors++;
        if (obs_b !== e) begin
          miscompares++;
          $display("FAIL nofwd_cfg t=%0t: got %h required %h", $time, obs_b, e);
        end
      end
    end
  end

endmodule
